// File: rtl/div_nbit_seq_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// master: the ALU controller side (drives start/operands).
// slave : the divider side (drives status and results).
interface div_nbit_seq_if #(
  parameter int N = 8
);
  logic             start;
  logic [2*N-1:0]   x;
  logic [N-1:0]     y;
  logic             ready;
  logic             done;
  logic [N-1:0]     q;
  logic [N-1:0]     r;
  logic             ovf;
  logic             dz;

  modport master (
    output start, x, y,
    input  ready, done, q, r, ovf, dz
  );

  modport slave (
    input  start, x, y,
    output ready, done, q, r, ovf, dz
  );
endinterface

// File: rtl/div_nbit_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock under a start/ready/done handshake. Overflow (quotient wider
// than N bits) and divide-by-zero exit early with q=all-ones, r=x[N-1:0].
// Optional feature macro: DIV_ZERO_FLAG_EN -- when defined, a zero divisor
// raises dz; when undefined, dz is tied low and y==0 reports as overflow.
module div_nbit_seq #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  div_nbit_seq_if.slave bus
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N:0]      p_q, p_d;      // partial remainder, one guard bit
  logic [N-1:0]    a_q, a_d;      // dividend low half, shifts into quotient
  logic [N-1:0]    y_q, y_d;      // latched divisor
  logic [CW-1:0]   cnt_q, cnt_d;  // remaining iterations minus one
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic            ovf_q, ovf_d;
`ifdef DIV_ZERO_FLAG_EN
  logic            dz_q, dz_d;
`endif

  logic [N:0]      t;
  logic [N:0]      diff;
  logic            ge;

  // Register all state and results; reset clears everything to the idle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      a_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Next-state, datapath step and result capture; results only change on
  // the transition into DONE.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif

    t    = {p_q[N-1:0], a_q[N-1]};
    ge   = (t >= {1'b0, y_q});
    diff = t - {1'b0, y_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          y_d = bus.y;
`ifdef DIV_ZERO_FLAG_EN
          if (bus.y == '0) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = bus.x[N-1:0];
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else
`endif
          // With the zero flag disabled, y==0 always lands here (hi >= 0).
          if (bus.x[2*N-1:N] >= bus.y) begin
            state_d = S_DONE;
            q_d     = '1;
            r_d     = bus.x[N-1:0];
            ovf_d   = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            dz_d    = 1'b0;
`endif
          end else begin
            state_d = S_CALC;
            p_d     = {1'b0, bus.x[2*N-1:N]};
            a_d     = bus.x[N-1:0];
            cnt_d   = CW'(N - 1);
          end
        end
      end

      S_CALC: begin
        p_d = ge ? diff : t;
        a_d = {a_q[N-2:0], ge};
        if (cnt_q == '0) begin
          state_d = S_DONE;
          q_d     = a_d;
          r_d     = p_d[N-1:0];
          ovf_d   = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
          dz_d    = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.ovf   = ovf_q;
`ifdef DIV_ZERO_FLAG_EN
  assign bus.dz    = dz_q;
`else
  assign bus.dz    = 1'b0;
`endif

endmodule

// File: tb/tb_div_nbit_seq.sv
// Self-checking bench for div_nbit_seq (N=8): directed vector table, start
// ignored during CALC, reset mid-operation, and a 2000-pair sweep with start
// held high. Honours DIV_ZERO_FLAG_EN for the zero-divisor expectations.
module tb_div_nbit_seq;
  localparam int N = 8;
  localparam int LAT_NORM = N + 1;  // negedges from accepting edge to done
  localparam int LAT_ERR  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_nbit_seq_if #(.N(N)) bus ();
  div_nbit_seq #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic.
  task automatic model(input logic [15:0] x, input logic [7:0] y,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ovf, output logic dz, output int lat);
    int unsigned xi, yi;
    xi = x;
    yi = y;
    if (y == 8'd0) begin
      q = 8'hFF; r = x[7:0]; lat = LAT_ERR;
`ifdef DIV_ZERO_FLAG_EN
      ovf = 1'b0; dz = 1'b1;
`else
      ovf = 1'b1; dz = 1'b0;
`endif
    end else if (x[15:8] >= y) begin
      q = 8'hFF; r = x[7:0]; ovf = 1'b1; dz = 1'b0; lat = LAT_ERR;
    end else begin
      q = 8'(xi / yi); r = 8'(xi % yi); ovf = 1'b0; dz = 1'b0; lat = LAT_NORM;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_op(input string nm, input logic [15:0] x, input logic [7:0] y,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic eovf, input logic edz, input int elat,
                        input bit keep);
    int lat;
    chk({nm, ".ready_pre"}, bus.ready, 1'b1);
    bus.start = 1'b1;
    bus.x = x;
    bus.y = y;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (!keep) bus.start = 1'b0;
      bus.x = ~x;  // operands may change freely after acceptance
      bus.y = ~y;
      if (bus.done || lat > N + 6) break;
    end
    done_cyc = cyc;
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".q"}, bus.q, eq);
    chk({nm, ".r"}, bus.r, er);
    chk({nm, ".ovf"}, bus.ovf, eovf);
    chk({nm, ".dz"}, bus.dz, edz);
    @(negedge clk);
    chk({nm, ".done_1cyc"}, bus.done, 1'b0);
    chk({nm, ".ready_post"}, bus.ready, 1'b1);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [7:0]  y;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] mq, mr;
    logic mo, md;
    int ml, saw;
    logic [15:0] rx;
    logic [7:0] ry;
    int unsigned mode;

    vecs[0] = '{16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, LAT_NORM};
    vecs[1] = '{16'hFEFF, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, LAT_NORM};
    vecs[2] = '{16'h0700, 8'd7,   8'hFF,  8'h00,  1'b1, 1'b0, LAT_ERR};
`ifdef DIV_ZERO_FLAG_EN
    vecs[3] = '{16'h1234, 8'd0,   8'hFF,  8'h34,  1'b0, 1'b1, LAT_ERR};
`else
    vecs[3] = '{16'h1234, 8'd0,   8'hFF,  8'h34,  1'b1, 1'b0, LAT_ERR};
`endif
    vecs[4] = '{16'd255,  8'd16,  8'd15,  8'd15,  1'b0, 1'b0, LAT_NORM};
    vecs[5] = '{16'hFFFF, 8'd1,   8'hFF,  8'hFF,  1'b1, 1'b0, LAT_ERR};
    vecs[6] = '{16'h0001, 8'd3,   8'd0,   8'd1,   1'b0, 1'b0, LAT_NORM};
    vecs[7] = '{16'h7FFF, 8'h80,  8'd255, 8'd127, 1'b0, 1'b0, LAT_NORM};
    vecs[8] = '{16'h0600, 8'd7,   8'd219, 8'd3,   1'b0, 1'b0, LAT_NORM};

    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst.ready", bus.ready, 1'b1);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.q", bus.q, 8'd0);
    chk("rst.r", bus.r, 8'd0);
    chk("rst.ovf", bus.ovf, 1'b0);
    chk("rst.dz", bus.dz, 1'b0);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r,
             vecs[i].ovf, vecs[i].dz, vecs[i].lat, 1'b0);
    end

    // start with different operands while busy must be ignored.
    bus.start = 1'b1; bus.x = 16'd1000; bus.y = 8'd7;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.x = 16'h0700; bus.y = 8'd7;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    saw = 0;
    for (int k = 0; k < 12 && !bus.done; k++) @(negedge clk);
    chk("busy.done_seen", bus.done, 1'b1);
    chk("busy.q", bus.q, 8'd142);
    chk("busy.r", bus.r, 8'd6);
    chk("busy.ovf", bus.ovf, 1'b0);
    @(negedge clk);
    for (int k = 0; k < N + 4; k++) begin
      if (bus.done) saw++;
      @(negedge clk);
    end
    chk("busy.no_second_done", saw, 0);

    // Reset during CALC iteration 4: operation abandoned, outputs cleared.
    bus.start = 1'b1; bus.x = 16'd1000; bus.y = 8'd7;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midrst.ready", bus.ready, 1'b1);
    chk("midrst.done", bus.done, 1'b0);
    chk("midrst.q", bus.q, 8'd0);
    chk("midrst.r", bus.r, 8'd0);
    chk("midrst.ovf", bus.ovf, 1'b0);
    chk("midrst.dz", bus.dz, 1'b0);
    saw = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (bus.done) saw++;
      @(negedge clk);
    end
    chk("midrst.no_done", saw, 0);
    run_op("postrst", 16'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0, LAT_NORM, 1'b0);

    // Sweep with start held high: back-to-back operations.
    for (int i = 0; i < 2000; i++) begin
      int prev;
      prev = done_cyc;
      mode = $urandom_range(0, 7);
      ry = 8'($urandom_range(0, 255));
      if (mode == 0) ry = 8'd0;
      rx[7:0] = 8'($urandom);
      if (ry != 8'd0 && mode < 6) rx[15:8] = 8'($urandom_range(0, int'(ry) - 1));
      else rx[15:8] = 8'($urandom);
      model(rx, ry, mq, mr, mo, md, ml);
      run_op($sformatf("sweep%0d", i), rx, ry, mq, mr, mo, md, ml, 1'b1);
      if (i > 0) chk($sformatf("sweep%0d.spacing", i), done_cyc - prev, ml + 1);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
